// File: rtl/darkram_arbiter.sv
// darkram_arbiter: round-robin two-master arbiter and wait-state sequencer for the single-port data RAM
module darkram_arbiter #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          M0_RD,
    input  logic          M0_WR,
    input  logic [3:0]    M0_BE,
    input  logic [31:0]   M0_ADDR,
    input  logic [31:0]   M0_DATAO,
    output logic          M0_ACK,
    output logic          M0_HLT,
    input  logic          M1_RD,
    input  logic          M1_WR,
    input  logic [3:0]    M1_BE,
    input  logic [31:0]   M1_ADDR,
    input  logic [31:0]   M1_DATAO,
    output logic          M1_ACK,
    output logic [31:0]   DATAI,
    output logic          RAM_EN,
    output logic          RAM_WR,
    output logic [3:0]    RAM_BE,
    output logic [AW-1:0] RAM_ADDR,
    output logic [31:0]   RAM_DATAO,
    input  logic [31:0]   RAM_DATAI,
    output logic [1:0]    GNT
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       own_q, own_d;
    logic       first_q, first_d;
    logic       req0, req1, own_req, own_wr, busy, resp, sel;
    logic       unused_addr_bits;

    assign req0    = M0_RD | M0_WR;
    assign req1    = M1_RD | M1_WR;
    assign own_req = own_q ? req1 : req0;
    assign own_wr  = own_q ? M1_WR : M0_WR;
    assign busy    = state_q == BUSY;
    assign resp    = state_q == RESP;
    assign sel     = busy & own_q;

    // state, wait counter, owner and fairness registers
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            first_q <= first_d;
        end
    end

    // arbitration, wait-state countdown and abort detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: if (req0 | req1) begin
                own_d   = (req0 & req1) ? ~last_q : req1;
                cnt_d   = 3'(WAIT);
                first_d = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (!own_req) state_d = IDLE;
                  else if (cnt_q == 3'd0) state_d = RESP;
                  else cnt_d = cnt_q - 3'd1;
            RESP: begin
                last_d  = own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign GNT       = (state_q == IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
    assign RAM_EN    = busy;
    assign RAM_WR    = busy & first_q & own_wr;
    assign RAM_BE    = busy ? (own_q ? M1_BE : M0_BE) : 4'b0000;
    assign RAM_ADDR  = sel ? M1_ADDR[AW+1:2] : M0_ADDR[AW+1:2];
    assign RAM_DATAO = sel ? M1_DATAO : M0_DATAO;
    assign DATAI     = RAM_DATAI;
    assign M0_ACK    = resp & ~own_q;
    assign M1_ACK    = resp & own_q;
    assign M0_HLT    = req0 & ~M0_ACK;

    // byte-offset and out-of-range address bits never reach the RAM
    assign unused_addr_bits = ^{M0_ADDR[31:AW+2], M0_ADDR[1:0], M1_ADDR[31:AW+2], M1_ADDR[1:0]};
endmodule

// File: doc/darkram_arbiter.md
# darkram_arbiter

Two-master arbiter and access sequencer for the SoC's single-port data RAM. It shares the RAM between the core data port (master 0) and a second bus master such as a DMA or debug loader (master 1). It grants one transfer at a time with round-robin fairness and inserts a programmable number of wait states. It also returns a per-master acknowledge and a core halt signal that replaces the DACK/DHIT wait logic in the SoC top.

## Interface

Parameters:
- AW, 10, RAM word-address width; RAM holds 2^AW 32-bit words.
- WAIT, 0, extra wait cycles per access, legal range 0..7.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RES  in  1  reset, asynchronous, active-low.
- M0_RD / M0_WR  in  1 each  core read / write request.
- M0_BE  in  4  core byte enables.
- M0_ADDR  in  32  core byte address.
- M0_DATAO  in  32  core write data.
- M0_ACK  out  1  one-cycle completion pulse to core.
- M0_HLT  out  1  core stall, high while a core request is pending and not yet acknowledged.
- M1_RD, M1_WR, M1_BE, M1_ADDR, M1_DATAO, M1_ACK  same as master 0, for master 1.
- DATAI  out  32  read data shared by both masters; valid only in the ACK cycle.
- RAM_EN  out  1  RAM access enable.
- RAM_WR  out  1  RAM write strobe.
- RAM_BE  out  4  RAM byte enables.
- RAM_ADDR  out  AW  RAM word address = owner ADDR[AW+1:2].
- RAM_DATAO  out  32  RAM write data.
- RAM_DATAI  in  32  RAM registered read data, valid one cycle after RAM_EN.
- GNT  out  2  one-hot current owner; 00 when idle.

## Operation

- A request is RD|WR on a master. Masters hold ADDR/BE/DATAO/RD/WR stable until their ACK. Asserting RD and WR together is treated as a write.
- State machine, 3 states:
  - IDLE: if no request, stay. Otherwise pick the owner, load the wait counter CNT with WAIT, and go to BUSY.
    - Only one master requesting: that master wins.
    - Both requesting: the master not in LAST wins.
  - BUSY:
    - RAM_EN=1 every cycle. RAM_ADDR/RAM_BE/RAM_DATAO come from the owner.
    - RAM_WR=1 only in the first BUSY cycle, and only if the owner's WR is set.
    - If CNT==0, go to RESP; else CNT decrements.
  - RESP: owner's ACK=1 for exactly this cycle and DATAI=RAM_DATAI. Set LAST=owner, GNT returns to 00 on exit, and go to IDLE.
- Abort: if the owner deasserts both RD and WR in BUSY, go to IDLE with no ACK. A write already strobed stays committed. LAST is not updated.
- HLT: M0_HLT = (M0_RD|M0_WR) & ~M0_ACK, combinational. Master 1 has no halt output and polls ACK.
- Outputs outside BUSY: RAM_EN, RAM_WR and RAM_BE are 0; RAM_ADDR and RAM_DATAO are don't-care but driven from master 0. DATAI outside RESP is don't-care.
- Reset (RES=0, asynchronous): state=IDLE, CNT=0, LAST=1 (so master 0 wins the first tie), GNT=00. M0_ACK, M1_ACK, RAM_EN and RAM_WR are 0. M0_HLT follows its equation. A reset during BUSY or RESP drops the transfer with no ACK.

## Timing

- Request first seen in IDLE at cycle T:
  - BUSY occupies T+1 .. T+1+WAIT.
  - ACK and valid DATAI occur at T+2+WAIT.
  - Next arbitration in IDLE at T+3+WAIT.
- Transfer occupancy is WAIT+3 cycles. Under contention the masters alternate strictly.
- Write commit: the RAM samples the write at the end of the first BUSY cycle, cycle T+1.
- Read data: RAM_DATAI in RESP reflects the address from the last BUSY cycle.
- A request arriving while the other master is in BUSY/RESP waits. It is arbitrated in the following IDLE cycle.
- CNT is 3 bits wide. A WAIT value above 7 is illegal and is not checked in RTL.

## Test plan

- Reset, WAIT=0, M0 reads address 0x0000_0010 with RAM word 4 = 0xDEADBEEF: GNT=01 at T+1, RAM_ADDR=4, M0_ACK pulse at T+2 with DATAI=0xDEADBEEF. M0_HLT is high T..T+1 and low at T+2.
- M0 writes 0x11223344 to byte address 0x8 with BE=0011, WAIT=2: RAM_WR high only at T+1, with RAM_BE=0011 and RAM_ADDR=2. M0_ACK at T+4. A following read of 0x8 returns 0x????3344.
- M0 and M1 request reads in the same cycle after reset: M0 is acked first, at T+2. M1 gets GNT=10 at T+4 and its ACK at T+5. With both still requesting, the owner sequence alternates M0, M1, M0, …
- M1 streams back-to-back writes while M0 requests once mid-stream: M0 is granted at the next IDLE and is never delayed more than one M1 transfer (at most 2·(WAIT+3) cycles).
- M1 deasserts WR during BUSY with WAIT=3: no M1_ACK, return to IDLE next cycle. The RAM write from the first BUSY cycle is present, and LAST is unchanged.
- RES pulsed low during BUSY of an M0 read: no ACK, GNT=00 immediately. After release, a new M0 request completes normally at T+2+WAIT.
